// File: rtl/ofdm_pkg.sv
// Shared OFDM constants and types for the 256-point FFT receive and transmit chains.
package ofdm_pkg;

    localparam int unsigned FFT_N          = 256;
    localparam int unsigned SAMPLE_W       = 16;
    localparam int unsigned IDX_W          = $clog2(FFT_N);
    // Default cyclic-prefix length, shared with the transmit-side CP inserter
    localparam int unsigned CP_LEN_DEFAULT = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [IDX_W-1:0]           idx_t;

    typedef enum logic [1:0] {
        IDLE,
        CP,
        BODY
    } cp_state_e;

endpackage

// File: rtl/cp_strip_256_if.sv
// Sample-stream bundle between the sample-alignment logic, the CP stripper and the FFT input.
interface cp_strip_256_if;
    import ofdm_pkg::*;

    logic    in_valid;
    logic    in_sync;
    sample_t x_real;
    sample_t x_img;
    sample_t y_real;
    sample_t y_img;
    logic    out_valid;
    idx_t    sample_idx;
    logic    frame_done;
    logic    frame_err;

    modport master (
        output in_valid, in_sync, x_real, x_img,
        input  y_real, y_img, out_valid, sample_idx, frame_done, frame_err
    );

    modport slave (
        input  in_valid, in_sync, x_real, x_img,
        output y_real, y_img, out_valid, sample_idx, frame_done, frame_err
    );

endinterface

// File: rtl/cp_strip_ctrl.sv
// Symbol framing state machine: tracks CP/BODY position and produces registered strobes.
module cp_strip_ctrl
    import ofdm_pkg::*;
#(
    parameter int unsigned CP_LEN = CP_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_sync,
    output logic take,
    output logic emit,
    output idx_t idx,
    output logic done,
    output logic err
);

    localparam bit   CpOne   = (CP_LEN == 1);
    localparam idx_t CpLast  = idx_t'(CP_LEN - 1);
    localparam idx_t IdxLast = idx_t'(FFT_N - 1);

    cp_state_e state;
    idx_t      cnt;

    // Samples that will appear on the output one cycle later
    assign take = (state == BODY) && in_valid && !in_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            emit  <= 1'b0;
            idx   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            emit <= 1'b0;
            idx  <= '0;
            done <= 1'b0;
            err  <= 1'b0;
            if (in_valid && in_sync) begin
                // A sync sample always opens a new CP; mid-symbol it also aborts the old one
                err   <= (state != IDLE);
                state <= CpOne ? BODY : CP;
                cnt   <= CpOne ? idx_t'(0) : idx_t'(1);
            end else begin
                unique case (state)
                    IDLE: ;
                    CP: begin
                        if (in_valid) begin
                            if (cnt == CpLast) begin
                                state <= BODY;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + idx_t'(1);
                            end
                        end
                    end
                    BODY: begin
                        if (!in_valid) begin
                            err   <= 1'b1;
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            emit <= 1'b1;
                            idx  <= cnt;
                            if (cnt == IdxLast) begin
                                done  <= 1'b1;
                                state <= IDLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + idx_t'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/cp_strip_256.sv
// Cyclic-prefix remover feeding the 256-point FFT; optional CP_STRIP_ERR_CNT_EN adds err_count.
module cp_strip_256
    import ofdm_pkg::*;
#(
    parameter int unsigned CP_LEN = CP_LEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    cp_strip_256_if.slave        bus
`ifdef CP_STRIP_ERR_CNT_EN
    ,
    output logic [15:0]          err_count
`endif
);

    logic    take;
    logic    emit;
    idx_t    idx;
    logic    done;
    logic    err;
    sample_t y_real_q;
    sample_t y_img_q;

    cp_strip_ctrl #(
        .CP_LEN (CP_LEN)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .in_sync  (bus.in_sync),
        .take     (take),
        .emit     (emit),
        .idx      (idx),
        .done     (done),
        .err      (err)
    );

    // Data is forced to zero whenever no sample is being emitted
    always_ff @(posedge clk) begin
        if (rst) begin
            y_real_q <= '0;
            y_img_q  <= '0;
        end else if (take) begin
            y_real_q <= bus.x_real;
            y_img_q  <= bus.x_img;
        end else begin
            y_real_q <= '0;
            y_img_q  <= '0;
        end
    end

    assign bus.y_real     = y_real_q;
    assign bus.y_img      = y_img_q;
    assign bus.out_valid  = emit;
    assign bus.sample_idx = idx;
    assign bus.frame_done = done;
    assign bus.frame_err  = err;

`ifdef CP_STRIP_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cp_strip_256.sv
// Directed bench for cp_strip_256: scenario table with burst/strobe expectations plus corner sequences.
module tb_cp_strip_256;
    import ofdm_pkg::*;

    localparam int CPL = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp_strip_256_if bus ();
`ifdef CP_STRIP_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    cp_strip_256 #(
        .CP_LEN (CPL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef CP_STRIP_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    typedef struct {
        string name;
        int    n_sym;
        int    cp_gap;
        int    body_gap_at;
        int    resync_at;
        int    exp_nb;
        int    s0, s1, s2;
        int    l0, l1, l2;
        int    exp_done;
        int    exp_err_cyc;
    } vec_t;

    vec_t  vecs[5];
    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc;
    bit    mon_en = 1'b0;
    bit    in_burst;
    int    exp_idx;
    int    n_done;
    int    starts[$];
    int    lens[$];
    int    err_cycs[$];
    string cur_name = "reset";

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0d, expected %0d", cur_name, nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        in_burst = 1'b0;
        exp_idx  = 0;
        n_done   = 0;
        starts.delete();
        lens.delete();
        err_cycs.delete();
    endtask

    task automatic observe();
        if (bus.out_valid) begin
            if (!in_burst) begin
                starts.push_back(cyc);
                in_burst = 1'b1;
                exp_idx  = 0;
            end
            check("idx", int'(bus.sample_idx), exp_idx);
            check("y_real", int'(bus.y_real), CPL + exp_idx);
            check("y_img", int'(bus.y_img), -(CPL + exp_idx));
            check("done_pos", int'(bus.frame_done), int'(exp_idx == 255));
            if (bus.frame_done) n_done++;
            exp_idx++;
        end else begin
            if (in_burst) begin
                lens.push_back(exp_idx);
                in_burst = 1'b0;
            end
            check("idle_y_real", int'(bus.y_real), 0);
            check("idle_y_img", int'(bus.y_img), 0);
            check("idle_idx", int'(bus.sample_idx), 0);
            check("idle_done", int'(bus.frame_done), 0);
        end
        if (bus.frame_err) begin
            err_cycs.push_back(cyc);
            check("err_with_valid", int'(bus.out_valid), 0);
        end
    endtask

    task automatic tick(input bit v, input bit s, input int n);
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.x_real   = 16'(n);
        bus.x_img    = 16'(-n);
        @(posedge clk);
        #1;
        if (mon_en) observe();
        cyc++;
    endtask

    task automatic reset_dut();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.x_real   = '0;
        bus.x_img    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        clear_mon();
    endtask

    task automatic run_vec(input vec_t v);
        int es[3];
        int el[3];
        es = '{v.s0, v.s1, v.s2};
        el = '{v.l0, v.l1, v.l2};
        reset_dut();
        cur_name = v.name;
        mon_en   = 1'b1;
        for (int s = 0; s < v.n_sym; s++) begin
            for (int n = 0; n < CPL + FFT_N; n++) begin
                if (s == 0 && v.cp_gap > 0 && n == 8) repeat (v.cp_gap) tick(1'b0, 1'b0, 0);
                if (s == 0 && v.body_gap_at >= 0 && n == CPL + v.body_gap_at) begin
                    repeat (4) tick(1'b0, 1'b0, 0);
                    break;
                end
                if (s == 0 && v.resync_at >= 0 && n == CPL + v.resync_at) break;
                tick(1'b1, n == 0, n);
            end
        end
        repeat (3) tick(1'b0, 1'b0, 0);
        mon_en = 1'b0;
        check("bursts", starts.size(), v.exp_nb);
        for (int b = 0; b < v.exp_nb && b < starts.size(); b++) check("burst_start", starts[b], es[b]);
        for (int b = 0; b < v.exp_nb && b < lens.size(); b++) check("burst_len", lens[b], el[b]);
        check("done_pulses", n_done, v.exp_done);
        check("err_pulses", err_cycs.size(), (v.exp_err_cyc >= 0) ? 1 : 0);
        if (v.exp_err_cyc >= 0 && err_cycs.size() > 0) check("err_cycle", err_cycs[0], v.exp_err_cyc);
    endtask

    initial begin
        //         name       nsym gap bgap  rsync nb  s0   s1   s2   l0   l1   l2  done errcyc
        vecs[0] = '{"nominal", 1,  0,  -1,   -1,   1,  16,  0,   0,   256, 0,   0,   1,   -1};
        vecs[1] = '{"b2b",     3,  0,  -1,   -1,   3,  16,  288, 560, 256, 256, 256, 3,   -1};
        vecs[2] = '{"cp_gap",  1,  5,  -1,   -1,   1,  21,  0,   0,   256, 0,   0,   1,   -1};
        vecs[3] = '{"body_gap", 2, 0,  100,  -1,   2,  16,  136, 0,   100, 256, 0,   1,   116};
        vecs[4] = '{"resync",  2,  0,  -1,   50,   2,  16,  82,  0,   50,  256, 0,   1,   66};

        reset_dut();
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_y_real", int'(bus.y_real), 0);
        check("rst_y_img", int'(bus.y_img), 0);
        check("rst_idx", int'(bus.sample_idx), 0);
        check("rst_done", int'(bus.frame_done), 0);
        check("rst_err", int'(bus.frame_err), 0);
`ifdef CP_STRIP_ERR_CNT_EN
        check("rst_err_count", int'(err_count), 0);
`endif

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Valid samples without sync in IDLE must be ignored
        reset_dut();
        cur_name = "idle_nosync";
        mon_en   = 1'b1;
        for (int n = 0; n < 20; n++) tick(1'b1, 1'b0, n);
        mon_en = 1'b0;
        check("bursts", starts.size(), 0);
        check("err_pulses", err_cycs.size(), 0);

        // Reset while BODY index 30 is being presented
        reset_dut();
        cur_name = "rst_mid_body";
        mon_en   = 1'b1;
        for (int n = 0; n < CPL + 30; n++) tick(1'b1, n == 0, n);
        rst = 1'b1;
        tick(1'b1, 1'b0, CPL + 30);
        check("out_valid", int'(bus.out_valid), 0);
        check("y_real", int'(bus.y_real), 0);
        check("y_img", int'(bus.y_img), 0);
        check("idx", int'(bus.sample_idx), 0);
        check("err", int'(bus.frame_err), 0);
        rst = 1'b0;
        for (int n = CPL + 31; n < CPL + 71; n++) tick(1'b1, 1'b0, n);
        mon_en = 1'b0;
        check("bursts", starts.size(), 1);
        if (lens.size() > 0) check("burst_len", lens[0], 30);
        check("err_pulses", err_cycs.size(), 0);

`ifdef CP_STRIP_ERR_CNT_EN
        // Continuous sync forces an abort every cycle after the first
        reset_dut();
        cur_name = "err_count_sat";
        repeat (70000) tick(1'b1, 1'b1, 0);
        repeat (2) tick(1'b0, 1'b0, 0);
        check("err_count", int'(err_count), 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cp_strip_256.md
# cp_strip_256

Receive-side OFDM front end that feeds the 256-point FFT core. It accepts a sample stream of 256-point symbols, each preceded by a cyclic prefix (CP). It discards the CP and emits exactly 256 contiguous samples per symbol, with the valid, index and framing strobes the FFT input expects. It is the mirror of the transmit chain (IFFT, then CP insertion) and sits between the ADC/sample-alignment logic and the forward FFT.

## Interface
- CP_LEN, 16, cyclic-prefix length in samples; legal range 1..255
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample qualifier
- in_sync  in  1  marks first CP sample of a symbol; only meaningful with in_valid=1
- x_real  in  16  signed input sample, real part
- x_img  in  16  signed input sample, imaginary part
- y_real  out  16  signed output sample, real part
- y_img  out  16  signed output sample, imaginary part
- out_valid  out  1  output qualifier; high for exactly 256 consecutive cycles per good symbol
- sample_idx  out  8  index 0..255 of the current output sample
- frame_done  out  1  one-cycle pulse coincident with sample_idx=255
- frame_err  out  1  one-cycle pulse on symbol abort

## Operation
- States are IDLE, CP and BODY. An 8-bit counter `cnt` counts samples within the current state.
- IDLE: waits for in_valid & in_sync, then enters CP with cnt=1. Samples without in_sync are ignored.
- CP: each valid sample increments cnt. Gaps (in_valid=0) pause the count with no error. When the sample that makes cnt==CP_LEN is accepted, go to BODY with cnt=0.
- BODY: each valid sample is emitted with sample_idx=cnt, then cnt increments. On the sample with cnt==255, pulse frame_done and return to IDLE.
- BODY gap: in_valid=0 while in BODY aborts the symbol. frame_err pulses, out_valid drops, and the state returns to IDLE. The FFT downstream requires contiguous input, so a gap cannot be tolerated.
- Resync mid-symbol: in_valid & in_sync while in CP or BODY pulses frame_err and restarts in CP with cnt=1. That sample counts as CP sample 1.
- in_sync asserted on the cycle right after BODY sample 255 starts the next symbol normally, with no error.
- Samples pass through unmodified. There is no arithmetic or width change.
- While out_valid=0, y_real, y_img and sample_idx are driven to 0.

## Timing
- All outputs are registered. Latency is 1 cycle from an accepted BODY sample to its output.
- Reset values: y_real=0, y_img=0, out_valid=0, sample_idx=0, frame_done=0, frame_err=0. State is IDLE and cnt=0.
- Reset has priority over all inputs, including a reset asserted mid-symbol. Output is zero on the cycle after rst is sampled high.
- frame_err is registered and appears 1 cycle after the offending input cycle.
- On a BODY-gap abort, out_valid is 0 in the same cycle that frame_err is 1.
- Throughput is one sample per cycle. A back-to-back symbol with no gaps takes CP_LEN+256 cycles.

## Configuration
- CP_STRIP_ERR_CNT_EN defined: adds output err_count [15:0].
  - Increments on every frame_err pulse and saturates at 16'hFFFF.
  - Reset value is 0.
- Undefined: the port and counter are absent. frame_err behaviour is unchanged.

## Structure
- The shared package `ofdm_pkg` holds:
  - FFT_N=256
  - SAMPLE_W=16
  - the state enum {IDLE, CP, BODY}
  - the default CP_LEN constant, shared with the transmit-side CP inserter
- One natural sub-module is `cp_strip_ctrl`: the state machine plus counter, producing the emit, idx, done and err strobes. The top level holds the output registers and the optional error counter.

## Test plan
- Nominal: CP_LEN=16, one symbol of 272 contiguous samples with x_real=n and x_img=-n (n=0..271), in_sync on n=0. Expected: 256 outputs, y_real=16..271, y_img=-16..-271, sample_idx=0..255, frame_done with idx 255, no frame_err.
- Back-to-back: three symbols, in_sync on cycles 0, 272 and 544. Expected: three 256-cycle out_valid bursts, each preceded by a 16-cycle out_valid=0 gap, and three frame_done pulses.
- CP gap: in_valid=0 for 5 cycles after CP sample 8. Expected: no error, and the output burst shifts by 5 cycles with contents unchanged.
- BODY gap: in_valid=0 at BODY index 100. Expected: frame_err pulse, out_valid low after 100 outputs, IDLE; the next in_sync symbol decodes cleanly.
- Resync: in_sync at BODY index 50. Expected: frame_err pulse, output stops, and the following 256 BODY samples emit with idx 0..255.
- Reset mid-BODY at idx 30: all outputs are 0 the next cycle. With CP_STRIP_ERR_CNT_EN, 70000 forced aborts leave err_count=16'hFFFF.
